// File: rtl/pulse_train_gen_if.sv
// Pulse train generator request/status bundle.
// master drives the request side, slave is the generator itself.
interface pulse_train_gen_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 8
);
  logic             start;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [REP_W-1:0] num_pulses;
  logic             abort;
  logic             sig_out;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] pulses_left;

  modport master (
    output start,
    output high_len,
    output low_len,
    output num_pulses,
    output abort,
    input  sig_out,
    input  busy,
    input  done,
    input  pulses_left
  );

  modport slave (
    input  start,
    input  high_len,
    input  low_len,
    input  num_pulses,
    input  abort,
    output sig_out,
    output busy,
    output done,
    output pulses_left
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Pulse train generator: one accepted start request produces num_pulses
// square pulses of high_len high cycles separated by max(low_len,1) low
// cycles. Every output comes straight from a flop.
module pulse_train_gen #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REP_W = 8
) (
  input logic               clk,
  input logic               rstn,
  pulse_train_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [REP_W-1:0] left_q, left_d;
  logic             done_q, done_d;
  logic             sig_q, sig_d;
  logic             busy_q, busy_d;

  // Low phase reload value; a zero low_len still yields one low cycle.
  logic [CNT_W-1:0] low_load;
  assign low_load = (low_q == '0) ? '0 : low_q - CNT_W'(1);

  // Next-state, counter and config latch logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    high_d  = high_q;
    low_d   = low_q;
    left_d  = left_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.abort) begin
          high_d = bus.high_len;
          low_d  = bus.low_len;
          if (bus.high_len == '0 || bus.num_pulses == '0) begin
            // Nothing to emit: report completion without going busy.
            done_d = 1'b1;
            left_d = '0;
          end else begin
            state_d = StHigh;
            cnt_d   = bus.high_len - CNT_W'(1);
            left_d  = bus.num_pulses - REP_W'(1);
          end
        end
      end

      StHigh: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
          left_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (left_q != '0) begin
          state_d = StLow;
          cnt_d   = low_load;
        end else begin
          // Last pulse ends without a trailing low phase.
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      StLow: begin
        if (bus.abort) begin
          state_d = StIdle;
          cnt_d   = '0;
          left_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = StHigh;
          cnt_d   = high_q - CNT_W'(1);
          left_d  = left_q - REP_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        left_d  = '0;
      end
    endcase

    // Outputs are registered copies of the next state decode.
    sig_d  = (state_d == StHigh);
    busy_d = (state_d != StIdle);
  end

  // State, counters, latched config and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      high_q  <= '0;
      low_q   <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      high_q  <= high_d;
      low_q   <= low_d;
      left_q  <= left_d;
      done_q  <= done_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.sig_out     = sig_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pulses_left = left_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: directed scenarios plus random
// traffic, all checked against a per-cycle expected-output queue.
module tb_pulse_train_gen;

  localparam int unsigned CW = 8;
  localparam int unsigned RW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  pulse_train_gen_if #(.CNT_W(CW), .REP_W(RW)) bus ();

  pulse_train_gen #(.CNT_W(CW), .REP_W(RW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct packed {
    logic          sig;
    logic          busy;
    logic          done;
    logic [RW-1:0] left;
  } obs_t;

  obs_t        cur;
  obs_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          rises = 0;
  int          falls = 0;
  logic        prev_sig = 1'b0;
  logic [63:0] sig_tr  = '0;
  logic [63:0] busy_tr = '0;
  logic [63:0] done_tr = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic s, input logic b, input logic d, input int l);
    obs_t e;
    e.sig  = s;
    e.busy = b;
    e.done = d;
    e.left = RW'(l);
    exp_q.push_back(e);
  endtask

  // Expected waveform of a whole accepted request, one entry per cycle.
  task automatic gen(input int h, input int l, input int n);
    if (h == 0 || n == 0) begin
      push(1'b0, 1'b0, 1'b1, 0);
      return;
    end
    for (int p = 0; p < n; p++) begin
      repeat (h) push(1'b1, 1'b1, 1'b0, n - 1 - p);
      if (p < n - 1) repeat ((l == 0) ? 1 : l) push(1'b0, 1'b1, 1'b0, n - 1 - p);
    end
    push(1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic model_edge();
    if (cur.busy && bus.abort) begin
      exp_q.delete();
    end else if (!cur.busy && bus.start && !bus.abort) begin
      exp_q.delete();
      gen(int'(bus.high_len), int'(bus.low_len), int'(bus.num_pulses));
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else cur = '0;
  endtask

  // One clock: update the model at the edge, compare 1ns later, return at negedge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_val({tag, " sig_out"}, 32'(bus.sig_out), 32'(cur.sig));
    check_val({tag, " busy"}, 32'(bus.busy), 32'(cur.busy));
    check_val({tag, " done"}, 32'(bus.done), 32'(cur.done));
    check_val({tag, " pulses_left"}, 32'(bus.pulses_left), 32'(cur.left));
    if (bus.sig_out && !prev_sig) rises++;
    if (!bus.sig_out && prev_sig) falls++;
    prev_sig = bus.sig_out;
    sig_tr  = {sig_tr[62:0], bus.sig_out};
    busy_tr = {busy_tr[62:0], bus.busy};
    done_tr = {done_tr[62:0], bus.done};
    @(negedge clk);
  endtask

  task automatic run(input string tag, input int k);
    repeat (k) tick(tag);
  endtask

  task automatic launch(input string tag, input int h, input int l, input int n);
    bus.high_len   = CW'(h);
    bus.low_len    = CW'(l);
    bus.num_pulses = RW'(n);
    bus.start      = 1'b1;
    tick(tag);
    bus.start      = 1'b0;
  endtask

  task automatic clear_counts();
    rises = 0;
    falls = 0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.high_len   = '0;
    bus.low_len    = '0;
    bus.num_pulses = '0;
    cur            = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("reset sig_out", 32'(bus.sig_out), 0);
    check_val("reset busy", 32'(bus.busy), 0);
    check_val("reset done", 32'(bus.done), 0);
    check_val("reset pulses_left", 32'(bus.pulses_left), 0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: reset during the second high phase, then a full train
    launch("t1", 4, 4, 5);
    run("t1", 9);
    check_val("t1 in 2nd high", 32'(bus.sig_out), 1);
    #2 rstn = 1'b0;
    #1;
    check_val("t1 async sig_out", 32'(bus.sig_out), 0);
    check_val("t1 async busy", 32'(bus.busy), 0);
    check_val("t1 async done", 32'(bus.done), 0);
    check_val("t1 async pulses_left", 32'(bus.pulses_left), 0);
    exp_q.delete();
    cur      = '0;
    prev_sig = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    clear_counts();
    launch("t1b", 4, 4, 5);
    run("t1b", 4 * 5 + 4 * 4 + 2);
    check_val("t1b rises", rises, 5);

    // 2: basic train
    clear_counts();
    launch("t2", 3, 2, 2);
    run("t2", 8);
    check_val("t2 sig pattern", 32'(sig_tr[8:0]), 32'(9'b111001110));
    check_val("t2 busy pattern", 32'(busy_tr[8:0]), 32'(9'b111111110));
    check_val("t2 done pattern", 32'(done_tr[8:0]), 32'(9'b000000001));
    check_val("t2 rises", rises, 2);
    run("t2 idle", 2);

    // 3: minimum timing, low_len=0 acts as 1
    clear_counts();
    launch("t3", 1, 0, 4);
    run("t3", 7);
    check_val("t3 sig pattern", 32'(sig_tr[7:0]), 32'(8'b10101010));
    check_val("t3 done at E8", 32'(bus.done), 1);
    check_val("t3 rises", rises, 4);
    check_val("t3 falls", falls, 4);
    run("t3 idle", 2);

    // 4: degenerate request, then busy-ignore
    launch("t4 deg", 3, 2, 0);
    check_val("t4 deg done", 32'(bus.done), 1);
    check_val("t4 deg busy", 32'(bus.busy), 0);
    run("t4 deg", 2);
    launch("t4 deg h0", 0, 2, 5);
    check_val("t4 h0 done", 32'(bus.done), 1);
    run("t4 h0", 2);
    clear_counts();
    launch("t4", 5, 5, 3);
    tick("t4");
    bus.start      = 1'b1;
    bus.num_pulses = RW'(9);
    bus.high_len   = CW'(1);
    bus.low_len    = CW'(1);
    tick("t4 restart");
    bus.start = 1'b0;
    run("t4", 3 * 5 + 2 * 5 + 1 - 3 + 2);
    check_val("t4 rises", rises, 3);

    // 5: abort in the 4th high cycle, then start+abort together in idle
    launch("t5", 10, 10, 3);
    run("t5", 3);
    bus.abort = 1'b1;
    tick("t5 abort");
    bus.abort = 1'b0;
    check_val("t5 abort sig_out", 32'(bus.sig_out), 0);
    check_val("t5 abort busy", 32'(bus.busy), 0);
    run("t5 after", 12);
    check_val("t5 no done", 32'(done_tr[12:0]), 0);
    clear_counts();
    bus.abort = 1'b1;
    launch("t5 both", 2, 2, 2);
    bus.abort = 1'b0;
    run("t5 both", 4);
    check_val("t5 both rises", rises, 0);

    // 6: back-to-back trains, start in the done cycle
    launch("t6", 2, 1, 1);
    run("t6", 2);
    check_val("t6 done cycle", 32'(bus.done), 1);
    launch("t6 b", 2, 1, 1);
    run("t6 b", 2);
    check_val("t6 sig pattern", 32'(sig_tr[5:0]), 32'(6'b110110));
    run("t6 idle", 2);

    // Random traffic: new config every cycle, occasional start and abort
    for (int i = 0; i < 600; i++) begin
      bus.start      = ($urandom_range(0, 7) == 0);
      bus.abort      = ($urandom_range(0, 49) == 0);
      bus.high_len   = CW'($urandom_range(0, 5));
      bus.low_len    = CW'($urandom_range(0, 3));
      bus.num_pulses = RW'($urandom_range(0, 4));
      tick("rand");
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    run("drain", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
Transmit-side counterpart to the team's edge detection logic. It turns a single start request into a registered, glitch-free square pulse train on sig_out, with programmable high time, low time and pulse count. The train is meant to drive downstream edge-sensitive logic, so every generated high and low phase lasts at least one full clk cycle. It also serves as the stimulus source for edge-detect checks on the test chip.

Parameters:
CNT_W, 8, width of high_len/low_len phase-length counters (max phase = 2^CNT_W-1 cycles)
REP_W, 8, width of num_pulses and pulses_left (max 2^REP_W-1 pulses per request)

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only when busy=0
high_len  input  CNT_W  high-phase length in cycles, latched on accepted start
low_len  input  CNT_W  low-phase length in cycles, latched on accepted start
num_pulses  input  REP_W  pulses to emit, latched on accepted start
abort  input  1  terminate current train
sig_out  output  1  generated waveform, driven directly from a flop
busy  output  1  train in progress (state != IDLE), registered
done  output  1  one-cycle strobe on normal completion, registered
pulses_left  output  REP_W  pulses not yet started, including none for the current one, registered

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; sig_out=0, busy=0, done=0, pulses_left=0; phase counter and latched config cleared. Reset mid-train aborts immediately, with no done.
- States: IDLE, HIGH, LOW. sig_out=1 only in HIGH.
- Accept: in IDLE with start=1 and abort=0, high_len, low_len and num_pulses are latched.
- Degenerate request: if high_len==0 or num_pulses==0, no pulse is emitted. Next cycle done=1 for one cycle, busy stays 0, state stays IDLE.
- low_len==0 is treated as 1, so a low phase is never shorter than one cycle.
- Normal start: start sampled at edge E0. At E1: state=HIGH, sig_out=1, busy=1, pulses_left=num_pulses-1. Latency from start to sig_out rising is 1 cycle.
- HIGH lasts exactly high_len cycles. On exit:
  - if pulses_left!=0, go to LOW with sig_out=0;
  - else go to IDLE with sig_out=0, busy=0, done=1 in that same cycle.
- LOW lasts exactly max(low_len,1) cycles, then goes to HIGH and decrements pulses_left.
- Period is high_len+max(low_len,1). Total busy cycles = N*high + (N-1)*low. No trailing low phase is timed.
- start while busy=1 is ignored; inputs are not re-latched. Config input changes mid-train have no effect.
- Back-to-back trains: start may be asserted in the done cycle (busy=0). The next HIGH then begins one cycle later, so at least one low cycle separates the trains.
- abort=1 while busy: at the next edge, state=IDLE, sig_out=0, busy=0, pulses_left=0, and done stays 0. A high phase may be truncated; this is allowed because abort is an explicit user action.
- abort and start together in IDLE: abort wins and start is dropped.
- abort in IDLE with no start: no effect.
- Counters are CNT_W and REP_W wide with no wrap-around. A phase counter loads len-1 and counts down to 0.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
1. Reset mid-train: high=4, low=4, n=5; pull rstn low at the 2nd high phase -> sig_out, busy, done and pulses_left go to 0 asynchronously; after release, a new start=1 runs a full train.
2. Basic train: high=3, low=2, n=2, start pulsed at E0 -> sig_out over E1..E9 = 1,1,1,0,0,1,1,1,0; busy=1 over E1..E8; done=1 only at E9; the bench counts exactly 2 rising edges.
3. Minimum timing: high=1, low=0, n=4 -> sig_out alternates 1,0,1,0,1,0,1,0 from E1; done at E8; 4 rising and 4 falling edges.
4. Degenerate and busy-ignore: n=0 -> done at E1, busy never 1, sig_out stays 0. Then high=5, low=5, n=3 with start re-pulsed during the 1st high phase carrying n=9 -> exactly 3 pulses.
5. Abort: high=10, low=10, n=3; abort at the 4th cycle of the 1st high phase -> sig_out=0 and busy=0 at the next edge, done never asserts; start and abort together in IDLE -> no pulse.
6. Back-to-back trains: high=2, low=1, n=1; start asserted in the done cycle with high=2, n=1 -> sig_out = 1,1,0,1,1,0, the second train rising exactly 1 cycle after the first done.
